// File: rtl/srio_ireq_pkt_gen.sv
// srio_ireq_pkt_gen: builds sRIO initiator-request packets (HELLO format) on the
// IREQ AXI4-Stream. Each accepted command produces one header beat; writes
// (FTYPE 5/6) follow it with size_m1[7:3]+1 generated data beats.
//
// Ports
//   log_clk, log_rst_n       clock, asynchronous active-low reset
//   cmd_valid / cmd_ready    command handshake
//   cmd_tid/ftype/ttype      header fields
//   cmd_size_m1, cmd_addr    transfer byte count minus 1, target address
//   m_axis_ireq_*            IREQ stream to the core (tuser = {SRC_ID, DEST_ID})
//   busy                     a packet is in progress
//   pkt_count                completed packets (wraps)
module srio_ireq_pkt_gen #(
    parameter logic [15:0] SRC_ID  = 16'h00FF,
    parameter logic [15:0] DEST_ID = 16'h00F0,
    parameter logic [1:0]  PRIO    = 2'b01
) (
    input  logic        log_clk,
    input  logic        log_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_tid,
    input  logic [3:0]  cmd_ftype,
    input  logic [3:0]  cmd_ttype,
    input  logic [7:0]  cmd_size_m1,
    input  logic [33:0] cmd_addr,
    output logic        m_axis_ireq_tvalid,
    input  logic        m_axis_ireq_tready,
    output logic        m_axis_ireq_tlast,
    output logic [63:0] m_axis_ireq_tdata,
    output logic [7:0]  m_axis_ireq_tkeep,
    output logic [31:0] m_axis_ireq_tuser,
    output logic        busy,
    output logic [15:0] pkt_count
);

    typedef enum logic [1:0] {StIdle, StHdr, StData, StDone} state_e;

    state_e      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        busy_q, busy_d;
    logic [15:0] pkt_count_q, pkt_count_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic [63:0] tdata_q, tdata_d;
    logic [7:0]  tkeep_q, tkeep_d;
    logic [31:0] tuser_q, tuser_d;
    logic        is_write_q, is_write_d;
    logic [4:0]  last_beat_q, last_beat_d;  // index of final data beat
    logic [4:0]  beat_q, beat_d;            // index of data beat on the bus
    logic [7:0]  base_q, base_d;            // byte-0 value of the next data beat

    logic accept;
    logic hs;

    // Byte i of a data beat is base + i (mod 256).
    function automatic logic [63:0] beat_data(input logic [7:0] base);
        logic [63:0] d;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            d[8*i +: 8] = base + 8'(i);
        end
        return d;
    endfunction

    // DONE also accepts, so back-to-back packets are separated by a single idle beat.
    assign accept = cmd_valid && cmd_ready_q && (state_q == StIdle || state_q == StDone);
    assign hs     = tvalid_q && m_axis_ireq_tready;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        busy_d      = busy_q;
        pkt_count_d = pkt_count_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        tuser_d     = tuser_q;
        is_write_d  = is_write_q;
        last_beat_d = last_beat_q;
        beat_d      = beat_q;
        base_d      = base_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    state_d     = StHdr;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    tvalid_d    = 1'b1;
                    tdata_d     = {cmd_tid, cmd_ftype, cmd_ttype, PRIO, 1'b0, 1'b0,
                                   cmd_size_m1, 2'b00, cmd_addr};
                    tkeep_d     = 8'hFF;
                    tuser_d     = {SRC_ID, DEST_ID};
                    is_write_d  = (cmd_ftype == 4'h5) || (cmd_ftype == 4'h6);
                    tlast_d     = !((cmd_ftype == 4'h5) || (cmd_ftype == 4'h6));
                    last_beat_d = cmd_size_m1[7:3];
                    base_d      = cmd_tid;
                    beat_d      = 5'd0;
                end else begin
                    state_d     = StIdle;
                    cmd_ready_d = 1'b1;
                end
            end
            StHdr: begin
                if (hs) begin
                    if (!is_write_q) begin
                        state_d     = StDone;
                        tvalid_d    = 1'b0;
                        tlast_d     = 1'b0;
                        busy_d      = 1'b0;
                        cmd_ready_d = 1'b1;
                        pkt_count_d = pkt_count_q + 16'd1;
                    end else begin
                        state_d = StData;
                        tdata_d = beat_data(base_q);
                        base_d  = base_q + 8'd8;
                        beat_d  = 5'd0;
                        tlast_d = (last_beat_q == 5'd0);
                    end
                end
            end
            StData: begin
                if (hs) begin
                    if (beat_q == last_beat_q) begin
                        state_d     = StDone;
                        tvalid_d    = 1'b0;
                        tlast_d     = 1'b0;
                        busy_d      = 1'b0;
                        cmd_ready_d = 1'b1;
                        pkt_count_d = pkt_count_q + 16'd1;
                    end else begin
                        beat_d  = beat_q + 5'd1;
                        tdata_d = beat_data(base_q);
                        base_d  = base_q + 8'd8;
                        tlast_d = ((beat_q + 5'd1) == last_beat_q);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            pkt_count_q <= 16'd0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= 64'd0;
            tkeep_q     <= 8'd0;
            tuser_q     <= 32'd0;
            is_write_q  <= 1'b0;
            last_beat_q <= 5'd0;
            beat_q      <= 5'd0;
            base_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            pkt_count_q <= pkt_count_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tuser_q     <= tuser_d;
            is_write_q  <= is_write_d;
            last_beat_q <= last_beat_d;
            beat_q      <= beat_d;
            base_q      <= base_d;
        end
    end

    assign cmd_ready          = cmd_ready_q;
    assign busy               = busy_q;
    assign pkt_count          = pkt_count_q;
    assign m_axis_ireq_tvalid = tvalid_q;
    assign m_axis_ireq_tlast  = tlast_q;
    assign m_axis_ireq_tdata  = tdata_q;
    assign m_axis_ireq_tkeep  = tkeep_q;
    assign m_axis_ireq_tuser  = tuser_q;

endmodule

// File: tb/tb_srio_ireq_pkt_gen.sv
// Bench for srio_ireq_pkt_gen: a packet-level model turns each command into the
// list of beats it must produce; the stream is compared beat by beat.
module tb_srio_ireq_pkt_gen;

    localparam logic [15:0] SRC = 16'h00FF;
    localparam logic [15:0] DST = 16'h00F0;
    localparam logic [1:0]  PR  = 2'b01;

    logic        log_clk = 1'b0;
    logic        log_rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_tid = '0;
    logic [3:0]  cmd_ftype = '0;
    logic [3:0]  cmd_ttype = '0;
    logic [7:0]  cmd_size_m1 = '0;
    logic [33:0] cmd_addr = '0;
    logic        tvalid;
    logic        tready = 1'b0;
    logic        tlast;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic [31:0] tuser;
    logic        busy;
    logic [15:0] pkt_count;

    always #5 log_clk = ~log_clk;

    srio_ireq_pkt_gen dut (
        .log_clk            (log_clk),
        .log_rst_n          (log_rst_n),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_tid            (cmd_tid),
        .cmd_ftype          (cmd_ftype),
        .cmd_ttype          (cmd_ttype),
        .cmd_size_m1        (cmd_size_m1),
        .cmd_addr           (cmd_addr),
        .m_axis_ireq_tvalid (tvalid),
        .m_axis_ireq_tready (tready),
        .m_axis_ireq_tlast  (tlast),
        .m_axis_ireq_tdata  (tdata),
        .m_axis_ireq_tkeep  (tkeep),
        .m_axis_ireq_tuser  (tuser),
        .busy               (busy),
        .pkt_count          (pkt_count)
    );

    typedef struct packed {
        logic [7:0]  tid;
        logic [3:0]  ftype;
        logic [3:0]  ttype;
        logic [7:0]  size_m1;
        logic [33:0] addr;
    } cmd_t;

    cmd_t        pend_q[$];
    logic [63:0] exp_data[$];
    bit          exp_last[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] model_cnt = '0;
    int          tr_mode = 0;   // 0 always ready, 1 pattern 1,0,0,1, 2 random, 3 stalled
    int          tr_phase = 0;
    int          hs_cnt = 0;
    int          last_cnt = 0;
    bit          held = 0;
    logic [63:0] held_data;
    logic        held_last;
    logic [7:0]  held_keep;
    logic [31:0] held_user;
    bit          gap_chk = 0;
    int          gap = -1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Packet-level reference: header word from field arithmetic, then data bytes.
    function automatic void model_pkt(input cmd_t c);
        logic [63:0] hdr;
        logic [63:0] w;
        bit          wr;
        int          n;
        wr  = (c.ftype == 4'h5) || (c.ftype == 4'h6);
        hdr = (64'(c.tid) << 56) | (64'(c.ftype) << 52) | (64'(c.ttype) << 48) |
              (64'(PR) << 46) | (64'(c.size_m1) << 36) | 64'(c.addr);
        exp_data.push_back(hdr);
        exp_last.push_back(!wr);
        if (wr) begin
            n = int'(c.size_m1) / 8 + 1;
            for (int k = 0; k < n; k++) begin
                w = '0;
                for (int i = 0; i < 8; i++) begin
                    w = w | (64'((int'(c.tid) + 8 * k + i) % 256) << (8 * i));
                end
                exp_data.push_back(w);
                exp_last.push_back(k == n - 1);
            end
        end
    endfunction

    task automatic enqueue(input logic [7:0] tid, input logic [3:0] ft, input logic [3:0] tt,
                           input logic [7:0] sz, input logic [33:0] ad);
        cmd_t c;
        c = '{tid: tid, ftype: ft, ttype: tt, size_m1: sz, addr: ad};
        pend_q.push_back(c);
        model_pkt(c);
    endtask

    // One cycle: observe at negedge, then drive inputs for the next posedge.
    task automatic step();
        logic [63:0] d;
        bit          l;
        @(negedge log_clk);
        if (held) begin
            check("hold_tvalid", 64'(tvalid), 64'd1);
            check("hold_tdata", tdata, held_data);
            check("hold_tlast", 64'(tlast), 64'(held_last));
            check("hold_tkeep", 64'(tkeep), 64'(held_keep));
            check("hold_tuser", 64'(tuser), 64'(held_user));
        end
        if (gap >= 0) begin
            if (tvalid) begin
                if (gap_chk) check("idle_gap", 64'(gap), 64'd1);
                gap = -1;
            end else begin
                gap++;
            end
        end
        if (tvalid) begin
            case (tr_mode)
                0: tready = 1'b1;
                1: tready = (tr_phase % 4 == 0) || (tr_phase % 4 == 3);
                2: tready = ($urandom % 10) < 7;
                default: tready = 1'b0;
            endcase
            tr_phase++;
            if (tready) begin
                held = 0;
                hs_cnt++;
                n_cmp++;
                assert (exp_data.size() != 0)
                else begin
                    n_bad++;
                    $error("FAIL beat_extra: observed beat %h expected none", tdata);
                end
                if (exp_data.size() != 0) begin
                    d = exp_data.pop_front();
                    l = exp_last.pop_front();
                    check("beat_tdata", tdata, d);
                    check("beat_tlast", 64'(tlast), 64'(l));
                    check("beat_tkeep", 64'(tkeep), 64'hFF);
                    check("beat_tuser", 64'(tuser), 64'({SRC, DST}));
                end
                if (tlast) begin
                    last_cnt++;
                    model_cnt = model_cnt + 16'd1;
                    gap = 0;
                end
            end else begin
                held      = 1;
                held_data = tdata;
                held_last = tlast;
                held_keep = tkeep;
                held_user = tuser;
            end
        end else begin
            held   = 0;
            tready = (tr_mode == 3) ? 1'b0 : 1'($urandom % 2);
        end
        if (pend_q.size() != 0) begin
            cmd_valid   = 1'b1;
            cmd_tid     = pend_q[0].tid;
            cmd_ftype   = pend_q[0].ftype;
            cmd_ttype   = pend_q[0].ttype;
            cmd_size_m1 = pend_q[0].size_m1;
            cmd_addr    = pend_q[0].addr;
            if (cmd_ready) void'(pend_q.pop_front());
        end else begin
            cmd_valid   = 1'b0;
            cmd_tid     = 8'($urandom);
            cmd_ftype   = 4'($urandom);
            cmd_ttype   = 4'($urandom);
            cmd_size_m1 = 8'($urandom);
            cmd_addr    = {2'($urandom), 32'($urandom)};
        end
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((pend_q.size() != 0 || exp_data.size() != 0 || busy) && c < budget) begin
            step();
            c++;
        end
        n_cmp++;
        assert (c < budget)
        else begin
            n_bad++;
            $error("FAIL drain_timeout: observed %0d cycles required below %0d", c, budget);
        end
        step();
        check("pkt_count", 64'(pkt_count), 64'(model_cnt));
        check("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        int h0, l0, i;

        // Reset state
        #12;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tlast", 64'(tlast), 64'd0);
        check("rst_tdata", tdata, 64'd0);
        check("rst_tkeep", 64'(tkeep), 64'd0);
        check("rst_tuser", 64'(tuser), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        @(negedge log_clk);
        log_rst_n = 1'b1;
        @(negedge log_clk);
        check("rel_cmd_ready", 64'(cmd_ready), 64'd1);

        // NREAD
        tr_mode = 0;
        enqueue(8'h01, 4'h2, 4'h4, 8'h07, 34'h0_1234_5678);
        drain(200);

        // NWRITE, 4 data beats
        enqueue(8'h10, 4'h5, 4'h4, 8'h1F, 34'h0_0000_1000);
        drain(200);

        // Same NWRITE under 1,0,0,1 backpressure
        tr_mode = 1; tr_phase = 0; h0 = hs_cnt; l0 = last_cnt;
        enqueue(8'h10, 4'h5, 4'h4, 8'h1F, 34'h0_0000_1000);
        drain(200);
        check("bp_handshakes", 64'(hs_cnt - h0), 64'd5);
        check("bp_tlast_count", 64'(last_cnt - l0), 64'd1);

        // Maximum size: 33 beats, data wraps
        tr_mode = 0; h0 = hs_cnt;
        enqueue(8'hF0, 4'h6, 4'h4, 8'hFF, 34'h3_FFFF_FFF8);
        drain(400);
        check("max_handshakes", 64'(hs_cnt - h0), 64'd33);

        // Long stall: nothing moves
        tr_mode = 3;
        enqueue(8'h44, 4'h5, 4'h4, 8'h17, 34'h1_0000_0040);
        for (int k = 0; k < 30; k++) step();
        check("stall_busy", 64'(busy), 64'd1);
        check("stall_tvalid", 64'(tvalid), 64'd1);
        check("stall_pkt_count", 64'(pkt_count), 64'(model_cnt));
        tr_mode = 0;
        drain(200);

        // Reset while data beat 2 is on the bus
        enqueue(8'h33, 4'h5, 4'h4, 8'h3F, 34'h0_0000_2000);
        h0 = hs_cnt; i = 0;
        while (hs_cnt - h0 < 3 && i < 100) begin
            step();
            i++;
        end
        check("rst_mid_reached", 64'(hs_cnt - h0), 64'd3);
        @(posedge log_clk);
        #2;
        check("rst_mid_beat2", tdata, exp_data[0]);
        log_rst_n = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check("rst_mid_tvalid", 64'(tvalid), 64'd0);
        check("rst_mid_tlast", 64'(tlast), 64'd0);
        check("rst_mid_pkt_count", 64'(pkt_count), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_cmd_ready", 64'(cmd_ready), 64'd0);
        pend_q.delete(); exp_data.delete(); exp_last.delete();
        model_cnt = '0; held = 0; gap = -1;
        @(negedge log_clk);
        log_rst_n = 1'b1;
        @(negedge log_clk);
        check("rst_mid_rel_ready", 64'(cmd_ready), 64'd1);

        // Back-to-back NREADs with cmd_valid held high
        gap_chk = 1;
        enqueue(8'hA1, 4'h2, 4'h4, 8'h07, 34'h0_0000_0100);
        enqueue(8'hA2, 4'h2, 4'h4, 8'h0F, 34'h0_0000_0200);
        enqueue(8'hA3, 4'h2, 4'h4, 8'h03, 34'h0_0000_0300);
        drain(200);
        check("b2b_pkt_count", 64'(pkt_count), 64'd3);
        gap_chk = 0;

        // Random commands with random backpressure
        tr_mode = 2;
        for (int k = 0; k < 25; k++) begin
            logic [3:0] ft;
            case ($urandom % 5)
                0: ft = 4'h2;
                1: ft = 4'h5;
                2: ft = 4'h6;
                3: ft = 4'hA;
                default: ft = 4'($urandom);
            endcase
            enqueue(8'($urandom), ft, 4'($urandom), 8'($urandom),
                    {2'($urandom), 32'($urandom)});
        end
        drain(8000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
